// File: rtl/biriscv_issue_fwd_pkg.sv
// ----------------------------------------------------------------------------
// biriscv_issue_fwd_pkg
// Shared definitions for the issue/forwarding slice: machine word and
// register-index widths, the E1/E2/WB tracking-slot layouts, and a helper
// that decides whether a source register is produced by a tracked slot.
// No ports (package).
// ----------------------------------------------------------------------------
package biriscv_issue_fwd_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Writer sitting in execute stage 1; its ALU result is on e1_result_i.
    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        logic     late;
    } e1_slot_t;

    // Writer in execute stage 2; late results arrive on e2_result_i.
    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        logic     late;
        word_t    value;
    } e2_slot_t;

    // Writer in write-back; value is final and drives the register file.
    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        word_t    value;
    } wb_slot_t;

    // x0 is never produced, so a zero source index never matches a slot.
    function automatic logic idx_hit(input reg_idx_t src,
                                     input logic     vld,
                                     input reg_idx_t rd);
        return vld && (src != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/biriscv_issue_fwd_if.sv
// ----------------------------------------------------------------------------
// biriscv_issue_fwd_if
// Bundles the decode-side input bus, the execute-side opcode bus, the
// pipeline control inputs (hold/flush), the execute result returns and the
// register-file write-back port of biriscv_issue_fwd.
//   slave  : view taken by biriscv_issue_fwd
//   master : view taken by the surrounding pipeline (or a testbench)
// ----------------------------------------------------------------------------
interface biriscv_issue_fwd_if;
    import biriscv_issue_fwd_pkg::*;

    logic     in_valid_i;
    word_t    in_opcode_i;
    word_t    in_pc_i;
    logic     in_invalid_i;
    reg_idx_t in_rd_idx_i;
    reg_idx_t in_ra_idx_i;
    reg_idx_t in_rb_idx_i;
    word_t    in_ra_value_i;
    word_t    in_rb_value_i;
    logic     in_late_i;
    logic     in_accept_o;

    logic     hold_i;
    logic     flush_i;
    word_t    e1_result_i;
    word_t    e2_result_i;

    logic     opcode_valid_o;
    word_t    opcode_opcode_o;
    word_t    opcode_pc_o;
    logic     opcode_invalid_o;
    reg_idx_t opcode_rd_idx_o;
    reg_idx_t opcode_ra_idx_o;
    reg_idx_t opcode_rb_idx_o;
    word_t    opcode_ra_operand_o;
    word_t    opcode_rb_operand_o;

    logic     wb_valid_o;
    reg_idx_t wb_rd_idx_o;
    word_t    wb_value_o;

    modport slave (
        input  in_valid_i, in_opcode_i, in_pc_i, in_invalid_i,
               in_rd_idx_i, in_ra_idx_i, in_rb_idx_i,
               in_ra_value_i, in_rb_value_i, in_late_i,
               hold_i, flush_i, e1_result_i, e2_result_i,
        output in_accept_o,
               opcode_valid_o, opcode_opcode_o, opcode_pc_o, opcode_invalid_o,
               opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o,
               opcode_ra_operand_o, opcode_rb_operand_o,
               wb_valid_o, wb_rd_idx_o, wb_value_o
    );

    modport master (
        output in_valid_i, in_opcode_i, in_pc_i, in_invalid_i,
               in_rd_idx_i, in_ra_idx_i, in_rb_idx_i,
               in_ra_value_i, in_rb_value_i, in_late_i,
               hold_i, flush_i, e1_result_i, e2_result_i,
        input  in_accept_o,
               opcode_valid_o, opcode_opcode_o, opcode_pc_o, opcode_invalid_o,
               opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o,
               opcode_ra_operand_o, opcode_rb_operand_o,
               wb_valid_o, wb_rd_idx_o, wb_value_o
    );

endinterface

// File: rtl/biriscv_fwd_mux.sv
// ----------------------------------------------------------------------------
// biriscv_fwd_mux
// Operand selection and hazard detection for one source register.
//   src_idx_i   : source register index
//   rf_value_i  : register-file read data for that index
//   e1_i/e2_i/wb_i : tracking slots
//   e1_result_i / e2_result_i : live execute results
//   operand_o   : value delivered to execute
//   hazard_o    : this operand cannot be satisfied this cycle
// Build option: BIRISCV_ISSUE_BYPASS_EN selects forwarding; without it the
// operand is always the register-file value and any in-flight writer of the
// source stalls issue until it has been written back.
// ----------------------------------------------------------------------------
module biriscv_fwd_mux
    import biriscv_issue_fwd_pkg::*;
(
    input  reg_idx_t src_idx_i,
    input  word_t    rf_value_i,
    input  e1_slot_t e1_i,
    input  word_t    e1_result_i,
    input  e2_slot_t e2_i,
    input  word_t    e2_result_i,
    input  wb_slot_t wb_i,
    output word_t    operand_o,
    output logic     hazard_o
);

    logic e1_hit;
    logic e2_hit;
    logic wb_hit;

    assign e1_hit = idx_hit(src_idx_i, e1_i.vld, e1_i.rd);
    assign e2_hit = idx_hit(src_idx_i, e2_i.vld, e2_i.rd);
    assign wb_hit = idx_hit(src_idx_i, wb_i.vld, wb_i.rd);

`ifdef BIRISCV_ISSUE_BYPASS_EN
    // Only a late producer in E1 has no value anywhere yet.
    assign hazard_o = e1_hit & e1_i.late;

    // Youngest writer wins; a late E1 hit is covered by the stall.
    always_comb begin
        operand_o = rf_value_i;
        if (src_idx_i == '0)
            operand_o = '0;
        else if (e1_hit && !e1_i.late)
            operand_o = e1_result_i;
        else if (e2_hit)
            operand_o = e2_i.late ? e2_result_i : e2_i.value;
        else if (wb_hit)
            operand_o = wb_i.value;
    end
`else
    // The register file is only coherent once the writer has left WB.
    assign hazard_o  = e1_hit | e2_hit | wb_hit;
    assign operand_o = rf_value_i;

    logic unused_fwd;
    assign unused_fwd = ^{e1_i.late, e1_result_i, e2_i.late, e2_i.value,
                          e2_result_i, wb_i.value};
`endif

endmodule

// File: rtl/biriscv_issue_fwd.sv
// ----------------------------------------------------------------------------
// biriscv_issue_fwd
// Single-issue operand-delivery stage in front of execute. Tracks in-flight
// writers through E1/E2/WB, forwards the newest value into both operands,
// stalls on unresolved hazards, and owns the register-file write port.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : in_* decode bus + in_accept_o, hold_i/flush_i,
//                  e1/e2 result returns, opcode_* to execute, wb_* port
// Build option: BIRISCV_ISSUE_BYPASS_EN enables operand forwarding (see
// biriscv_fwd_mux); otherwise hazards are resolved by stalling only.
// ----------------------------------------------------------------------------
module biriscv_issue_fwd
    import biriscv_issue_fwd_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    biriscv_issue_fwd_if.slave  bus
);

    e1_slot_t e1_p1;
    e2_slot_t e2_p2;
    wb_slot_t wb_p3;

    logic  ra_hazard;
    logic  rb_hazard;
    logic  stall;
    logic  issue;
    word_t ra_operand;
    word_t rb_operand;

    biriscv_fwd_mux u_fwd_ra (
        .src_idx_i   (bus.in_ra_idx_i),
        .rf_value_i  (bus.in_ra_value_i),
        .e1_i        (e1_p1),
        .e1_result_i (bus.e1_result_i),
        .e2_i        (e2_p2),
        .e2_result_i (bus.e2_result_i),
        .wb_i        (wb_p3),
        .operand_o   (ra_operand),
        .hazard_o    (ra_hazard)
    );

    biriscv_fwd_mux u_fwd_rb (
        .src_idx_i   (bus.in_rb_idx_i),
        .rf_value_i  (bus.in_rb_value_i),
        .e1_i        (e1_p1),
        .e1_result_i (bus.e1_result_i),
        .e2_i        (e2_p2),
        .e2_result_i (bus.e2_result_i),
        .wb_i        (wb_p3),
        .operand_o   (rb_operand),
        .hazard_o    (rb_hazard)
    );

    assign stall = ra_hazard | rb_hazard;
    assign issue = ~rst_i & bus.in_valid_i & ~bus.hold_i & ~bus.flush_i & ~stall;

    // A flush consumes the instruction even when it would have stalled.
    assign bus.in_accept_o = ~rst_i & bus.in_valid_i & ~bus.hold_i &
                             (bus.flush_i | ~stall);

    assign bus.opcode_valid_o      = issue;
    assign bus.opcode_opcode_o     = bus.in_opcode_i;
    assign bus.opcode_pc_o         = bus.in_pc_i;
    assign bus.opcode_invalid_o    = bus.in_invalid_i;
    assign bus.opcode_rd_idx_o     = bus.in_rd_idx_i;
    assign bus.opcode_ra_idx_o     = bus.in_ra_idx_i;
    assign bus.opcode_rb_idx_o     = bus.in_rb_idx_i;
    assign bus.opcode_ra_operand_o = ra_operand;
    assign bus.opcode_rb_operand_o = rb_operand;

    // A frozen WB slot must not be written twice.
    assign bus.wb_valid_o  = wb_p3.vld & ~bus.hold_i;
    assign bus.wb_rd_idx_o = wb_p3.rd;
    assign bus.wb_value_o  = wb_p3.value;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e1_p1 <= '0;
            e2_p2 <= '0;
            wb_p3 <= '0;
        end else if (!bus.hold_i) begin
            // issue -> E1
            e1_p1.vld   <= issue & (bus.in_rd_idx_i != '0);
            e1_p1.rd    <= bus.in_rd_idx_i;
            e1_p1.late  <= bus.in_late_i;
            // E1 -> E2
            e2_p2.vld   <= e1_p1.vld;
            e2_p2.rd    <= e1_p1.rd;
            e2_p2.late  <= e1_p1.late;
            e2_p2.value <= bus.e1_result_i;
            // E2 -> WB
            wb_p3.vld   <= e2_p2.vld;
            wb_p3.rd    <= e2_p2.rd;
            wb_p3.value <= e2_p2.late ? bus.e2_result_i : e2_p2.value;
        end
    end

endmodule

// File: tb/tb_biriscv_issue_fwd.sv
// ----------------------------------------------------------------------------
// tb_biriscv_issue_fwd
// Directed, table-driven bench for biriscv_issue_fwd. Each record is one
// clock cycle of stimulus plus the outputs expected in that cycle. Common
// vectors hold for both builds; build-specific sequences follow.
// ----------------------------------------------------------------------------
module tb_biriscv_issue_fwd;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    biriscv_issue_fwd_if bus();

    biriscv_issue_fwd dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] rav;
        logic [31:0] rbv;
        logic        late;
        logic        hold;
        logic        flush;
        logic [31:0] e1r;
        logic [31:0] e2r;
        logic        acc;
        logic        opv;
        logic [31:0] raop;
        logic [31:0] rbop;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbval;
    } vec_t;

    int tests  = 0;
    int fails  = 0;
    int vec_no = 0;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic v, input logic [4:0] rd,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic [31:0] rav, input logic [31:0] rbv,
        input logic late, input logic hold, input logic flush,
        input logic [31:0] e1r, input logic [31:0] e2r,
        input logic acc, input logic opv,
        input logic [31:0] raop, input logic [31:0] rbop,
        input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbval);
        vec_t t;
        t.rst = rst; t.v = v; t.rd = rd; t.ra = ra; t.rb = rb;
        t.rav = rav; t.rbv = rbv; t.late = late; t.hold = hold; t.flush = flush;
        t.e1r = e1r; t.e2r = e2r; t.acc = acc; t.opv = opv;
        t.raop = raop; t.rbop = rbop; t.wbv = wbv; t.wbrd = wbrd; t.wbval = wbval;
        return t;
    endfunction

    // Idle cycle: nothing offered, only the write-back port is predicted.
    function automatic vec_t idl(input logic [31:0] e1r, input logic [31:0] e2r,
                                 input logic wbv, input logic [4:0] wbrd,
                                 input logic [31:0] wbval);
        return mk(0,0,0,0,0,0,0,0,0,0,e1r,e2r, 0,0,0,0, wbv,wbrd,wbval);
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec%0d: got %h want %h", nm, vec_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk_i);
        #1;
        rst_i             = t.rst;
        bus.in_valid_i    = t.v;
        bus.in_opcode_i   = 32'h0000_0013 ^ vec_no;
        bus.in_pc_i       = vec_no * 4;
        bus.in_invalid_i  = 1'b0;
        bus.in_rd_idx_i   = t.rd;
        bus.in_ra_idx_i   = t.ra;
        bus.in_rb_idx_i   = t.rb;
        bus.in_ra_value_i = t.rav;
        bus.in_rb_value_i = t.rbv;
        bus.in_late_i     = t.late;
        bus.hold_i        = t.hold;
        bus.flush_i       = t.flush;
        bus.e1_result_i   = t.e1r;
        bus.e2_result_i   = t.e2r;
        @(negedge clk_i);
        check("accept", {31'b0, bus.in_accept_o},    {31'b0, t.acc});
        check("opv",    {31'b0, bus.opcode_valid_o}, {31'b0, t.opv});
        if (t.opv) begin
            check("ra_op", bus.opcode_ra_operand_o, t.raop);
            check("rb_op", bus.opcode_rb_operand_o, t.rbop);
            check("op_rd", {27'b0, bus.opcode_rd_idx_o}, {27'b0, t.rd});
            check("op_pc", bus.opcode_pc_o, vec_no * 4);
        end
        check("wb_valid", {31'b0, bus.wb_valid_o}, {31'b0, t.wbv});
        if (t.wbv || t.rst) begin
            check("wb_rd",  {27'b0, bus.wb_rd_idx_o}, {27'b0, t.wbrd});
            check("wb_val", bus.wb_value_o, t.wbval);
        end
        vec_no++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            bus.in_valid_i  = 1'b0;
            bus.hold_i      = 1'b0;
            bus.flush_i     = 1'b0;
            bus.e1_result_i = '0;
            bus.e2_result_i = '0;
        end
    endtask

    initial begin
        bus.in_valid_i = 0; bus.in_opcode_i = 0; bus.in_pc_i = 0;
        bus.in_invalid_i = 0; bus.in_rd_idx_i = 0; bus.in_ra_idx_i = 0;
        bus.in_rb_idx_i = 0; bus.in_ra_value_i = 0; bus.in_rb_value_i = 0;
        bus.in_late_i = 0; bus.hold_i = 0; bus.flush_i = 0;
        bus.e1_result_i = 0; bus.e2_result_i = 0;

        // rst, v, rd, ra, rb, rav, rbv, late, hold, flush, e1r, e2r | acc, opv, raop, rbop, wbv, wbrd, wbval
        tbl.push_back(mk(1,1,1,0,0,0,0,0,0,0,0,0,           0,0,0,0,         0,0,0));        // in reset
        tbl.push_back(idl(0,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0,0,0,0,0,0,0,0,           1,1,0,0,         0,0,0));        // addi x5
        tbl.push_back(mk(0,1,6,7,8,'h70,'h80,1,0,0,'h55,0,  1,1,'h70,'h80,   0,0,0));        // lw x6, independent
        tbl.push_back(mk(0,1,0,9,10,'h9,'hA,0,0,0,'h99,0,   1,1,'h9,'hA,     0,0,0));        // writer of x0
        tbl.push_back(mk(0,1,11,12,13,'hC,'hD,0,0,1,7,'h666, 1,0,0,0,        1,5,'h55));     // flush, x5 writes
        tbl.push_back(idl(0,0,1,6,'h666));                                                   // late x6 writes
        tbl.push_back(idl(0,0,0,0,0));                                                       // x0 never writes
        tbl.push_back(idl(0,0,0,0,0));                                                       // flushed never writes
        tbl.push_back(mk(0,1,14,0,0,0,0,0,0,0,0,0,          1,1,0,0,         0,0,0));        // x14
        tbl.push_back(mk(0,1,15,16,17,'h16,'h17,0,1,0,0,0,  0,0,0,0,         0,0,0));        // hold
        tbl.push_back(mk(0,1,15,16,17,'h16,'h17,0,1,0,0,0,  0,0,0,0,         0,0,0));        // hold
        tbl.push_back(idl('h140,0,0,0,0));
        tbl.push_back(idl(0,0,0,0,0));
        tbl.push_back(mk(0,1,15,16,17,'h16,'h17,0,1,0,0,0,  0,0,0,0,         0,0,0));        // hold masks WB
        tbl.push_back(idl(0,0,1,14,'h140));
        tbl.push_back(idl(0,0,0,0,0));
        tbl.push_back(mk(0,1,20,0,0,0,0,0,0,0,0,0,          1,1,0,0,         0,0,0));
        tbl.push_back(mk(0,1,21,0,0,0,0,0,0,0,'h200,0,      1,1,0,0,         0,0,0));
        tbl.push_back(mk(1,1,22,0,0,0,0,0,0,0,'h210,0,      0,0,0,0,         0,0,0));        // reset mid-flight
        tbl.push_back(mk(0,1,23,20,21,'hAAA,'hBBB,0,0,0,0,0, 1,1,'hAAA,'hBBB, 0,0,0));       // regfile values
        tbl.push_back(idl('h230,0,0,0,0));
        tbl.push_back(idl(0,0,0,0,0));
        tbl.push_back(idl(0,0,1,23,'h230));
        tbl.push_back(mk(0,1,7,0,0,0,0,0,0,0,0,0,           1,1,0,0,         0,0,0));        // add x7
        tbl.push_back(mk(0,1,8,0,0,0,0,0,0,1,'h77,0,        1,0,0,0,         0,0,0));        // flush, x7 in E1
        tbl.push_back(mk(0,1,9,0,0,0,0,1,0,0,0,0,           1,1,0,0,         0,0,0));        // lw x9
        tbl.push_back(mk(0,1,10,9,0,'h90,0,0,0,1,0,0,       1,0,0,0,         1,7,'h77));     // stall + flush
        tbl.push_back(idl(0,'h999,0,0,0));
        tbl.push_back(idl(0,0,1,9,'h999));
        tbl.push_back(idl(0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        drain(4);
`ifdef BIRISCV_ISSUE_BYPASS_EN
        // ALU->ALU, late->consumer, x0, E2 and WB forwarding
        apply(mk(0,1,1,0,0,0,0,0,0,0,0,0,             1,1,0,0,         0,0,0));
        apply(mk(0,1,2,1,1,0,0,0,0,0,5,0,             1,1,5,5,         0,0,0));
        apply(mk(0,1,3,0,0,0,0,1,0,0,7,0,             1,1,0,0,         0,0,0));
        apply(mk(0,1,4,3,0,0,0,0,0,0,'hdead,0,        0,0,0,0,         1,1,5));
        apply(mk(0,1,4,3,0,0,0,0,0,0,0,'h1234,        1,1,'h1234,0,    1,2,7));
        apply(mk(0,1,0,0,0,0,0,0,0,0,'h44,0,          1,1,0,0,         1,3,'h1234));
        apply(mk(0,1,5,0,0,'h77,'h77,0,0,0,7,0,       1,1,0,0,         0,0,0));
        apply(idl('h50,0,1,4,'h44));
        apply(mk(0,1,6,5,5,0,0,0,0,0,0,0,             1,1,'h50,'h50,   0,0,0));
        apply(mk(0,1,0,5,0,'h1,0,0,0,0,'h60,0,        1,1,'h50,0,      1,5,'h50));
        drain(4);
        // producer in E1 frozen by two hold cycles
        apply(mk(0,1,1,0,0,0,0,0,0,0,0,0,             1,1,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,0,0,0,1,0,0,0,             0,0,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,0,0,0,1,0,0,0,             0,0,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,0,0,0,0,0,'h31,0,          1,1,'h31,0,      0,0,0));
        apply(idl('h32,0,0,0,0));
        apply(idl(0,0,1,1,'h31));
        apply(idl(0,0,1,2,'h32));
`else
        // no forwarding: consumer waits until the writer has left WB
        apply(mk(0,1,1,0,0,0,0,0,0,0,0,0,             1,1,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,'h100,0,0,0,0,5,0,         0,0,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,'h100,0,0,0,0,0,0,         0,0,0,0,         0,0,0));
        apply(mk(0,1,2,1,0,'h100,0,0,0,0,0,0,         0,0,0,0,         1,1,5));
        apply(mk(0,1,2,1,0,'h100,0,0,0,0,0,0,         1,1,'h100,0,     0,0,0));
        apply(idl('h22,0,0,0,0));
        apply(idl(0,0,0,0,0));
        apply(idl(0,0,1,2,'h22));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
